// File: rtl/ext_int_ctl_if.sv
// ---------------------------------------------------------------------------
// ext_int_ctl_if -- data-bus view of the external interrupt controller.
//
// Signals:
//   addr   bus byte address            (master -> slave)
//   wdata  bus write data              (master -> slave)
//   rd     one-cycle read strobe       (master -> slave)
//   wr     one-cycle write strobe      (master -> slave)
//   rdata  read data, valid the cycle after rd  (slave -> master)
//   hit    combinational: access lands in a mapped register (slave -> master)
// ---------------------------------------------------------------------------
`ifndef ISA__XLEN
`define ISA__XLEN 32
`endif

interface ext_int_ctl_if;
  logic [`ISA__XLEN-1:0] addr;
  logic [`ISA__XLEN-1:0] wdata;
  logic                  rd;
  logic                  wr;
  logic [`ISA__XLEN-1:0] rdata;
  logic                  hit;

  modport master (output addr, output wdata, output rd, output wr,
                  input rdata, input hit);
  modport slave  (input addr, input wdata, input rd, input wr,
                  output rdata, output hit);
endinterface

// File: rtl/ext_int_ctl.sv
// ---------------------------------------------------------------------------
// ext_int_ctl -- platform external interrupt controller.
//
// Collects N_SRC peripheral requests (IDs 1..N_SRC, ID 0 = "none"), gates
// each one as edge or level, tracks pending / enable / in-service state and
// drives one registered interrupt request (exti) into the core. The core
// claims the highest-priority (lowest ID) request by reading CLAIM and
// signals completion by writing the ID back to CLAIM.
//
// Ports:
//   clk    core clock
//   rst_n  asynchronous active-low reset
//   src    request lines, bit i = source ID i, bit 0 ignored
//   bus    ext_int_ctl_if.slave: addr, wdata, rd, wr, rdata, hit
//   exti   registered external interrupt request to the core
//
// Register map (word offsets from BASE):
//   0x00 PENDING (ro)  0x04 ENABLE (rw)  0x08 TRIGGER (rw, 1=edge)
//   0x0C INSERVICE (ro)  0x10 CLAIM (read = claim, write = complete)
//
// Optional build macro EXT_INT_CTL_SYNC_EN: when defined, every src bit goes
// through a two-flop synchronizer before the gateway (src-to-exti latency 4
// cycles instead of 2). When undefined, src must be synchronous to clk.
// ---------------------------------------------------------------------------
`ifndef ISA__XLEN
`define ISA__XLEN 32
`endif

module ext_int_ctl #(
  parameter int unsigned N_SRC = 8,
  parameter logic [31:0] BASE  = 32'hF000_0000
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [N_SRC:0]   src,
  ext_int_ctl_if.slave     bus,
  output logic             exti
);

  localparam int XL = `ISA__XLEN;

  typedef logic [N_SRC:0] vec_t;

  // Bit 0 (ID "none") never holds state.
  localparam vec_t SRC_MASK = {{N_SRC{1'b1}}, 1'b0};

  localparam logic [2:0] OFF_PENDING   = 3'd0;
  localparam logic [2:0] OFF_ENABLE    = 3'd1;
  localparam logic [2:0] OFF_TRIGGER   = 3'd2;
  localparam logic [2:0] OFF_INSERVICE = 3'd3;
  localparam logic [2:0] OFF_CLAIM     = 3'd4;

  // State
  vec_t          pending_q,   pending_d;
  vec_t          enable_q,    enable_d;
  vec_t          trigger_q,   trigger_d;
  vec_t          inservice_q, inservice_d;
  vec_t          latch_q,     latch_d;
  vec_t          prev_q,      prev_d;
  logic          exti_q,      exti_d;
  logic [XL-1:0] rdata_q,     rdata_d;

  // Sampled request lines seen by the gateway
  vec_t src_s;

`ifdef EXT_INT_CTL_SYNC_EN
  vec_t sync1_q, sync1_d;
  vec_t sync2_q, sync2_d;

  // Synchronizer next-state: shift the raw lines two stages deep.
  always_comb begin
    sync1_d = src;
    sync2_d = sync1_q;
  end

  // Synchronizer flops; cleared by reset so no stale request survives it.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1_q <= {(N_SRC+1){1'b0}};
      sync2_q <= {(N_SRC+1){1'b0}};
    end else begin
      sync1_q <= sync1_d;
      sync2_q <= sync2_d;
    end
  end

  assign src_s = sync2_q;
`else
  assign src_s = src;
`endif

  // ---------------- Bus decode ----------------
  logic [2:0] off_s;
  logic       hit_s;
  logic       claim_rd_s;
  logic       cmpl_wr_s;
  logic       en_wr_s;
  logic       trig_wr_s;
  logic [4:0] cmpl_id_s;
  vec_t       wr_vec_s;

  assign off_s      = bus.addr[4:2];
  assign hit_s      = (bus.addr[31:5] == BASE[31:5]) && (off_s <= OFF_CLAIM);
  assign bus.hit    = hit_s;
  assign claim_rd_s = bus.rd && hit_s && (off_s == OFF_CLAIM);
  assign cmpl_wr_s  = bus.wr && hit_s && (off_s == OFF_CLAIM);
  assign en_wr_s    = bus.wr && hit_s && (off_s == OFF_ENABLE);
  assign trig_wr_s  = bus.wr && hit_s && (off_s == OFF_TRIGGER);
  assign cmpl_id_s  = bus.wdata[4:0];
  assign wr_vec_s   = bus.wdata[N_SRC:0] & SRC_MASK;

  // Byte-lane bits and wide write-data bits carry no meaning here.
  logic unused_bits_s;
  assign unused_bits_s = ^{bus.addr[1:0], bus.wdata};

  // ---------------- Claim arbitration ----------------
  logic [4:0] claim_id_s;

  // Lowest-numbered source that is both pending and enabled wins.
  always_comb begin
    claim_id_s = 5'd0;
    for (int i = N_SRC; i >= 1; i--) begin
      if (pending_q[i] && enable_q[i]) begin
        claim_id_s = 5'(i);
      end else begin
        claim_id_s = claim_id_s;
      end
    end
  end

  vec_t claim_vec_s;
  vec_t cmpl_vec_s;

  // One-hot views of the claimed ID and of a valid completion.
  always_comb begin
    claim_vec_s = {(N_SRC+1){1'b0}};
    cmpl_vec_s  = {(N_SRC+1){1'b0}};
    for (int i = 1; i <= N_SRC; i++) begin
      claim_vec_s[i] = claim_rd_s && (claim_id_s == 5'(i));
      cmpl_vec_s[i]  = cmpl_wr_s && (cmpl_id_s == 5'(i)) && inservice_q[i];
    end
  end

  // ---------------- Gateway ----------------
  vec_t rise_s;
  vec_t insv_after_s;
  vec_t from_latch_s;
  vec_t edge_set_s;
  vec_t edge_hold_s;
  vec_t lvl_set_s;
  vec_t trig_chg_s;

  assign rise_s       = src_s & ~prev_q & SRC_MASK;
  // In-service after this cycle's claim/complete; level requests are gated
  // against this so a completion with the line still high re-pends at once.
  assign insv_after_s = (inservice_q | claim_vec_s) & ~cmpl_vec_s & SRC_MASK;
  assign from_latch_s = cmpl_vec_s & latch_q;
  // An edge arriving while busy is remembered (1 deep) rather than dropped.
  assign edge_set_s   = rise_s & ~pending_q & ~inservice_q;
  assign edge_hold_s  = rise_s & (pending_q | inservice_q);
  assign lvl_set_s    = src_s & ~insv_after_s & SRC_MASK;
  assign trig_chg_s   = trig_wr_s ? (trigger_q ^ wr_vec_s) : {(N_SRC+1){1'b0}};

  // Per-source pending / in-service / edge-latch next state.
  always_comb begin
    pending_d   = ((pending_q & ~claim_vec_s)
                  | (trigger_q & (edge_set_s | from_latch_s))
                  | (~trigger_q & lvl_set_s)) & SRC_MASK;
    latch_d     = trigger_q & ((latch_q & ~from_latch_s) | edge_hold_s)
                  & ~trig_chg_s & SRC_MASK;
    inservice_d = insv_after_s;
    prev_d      = src_s & SRC_MASK;
    exti_d      = |(pending_q & enable_q);
  end

  // Software-writable ENABLE and TRIGGER registers.
  always_comb begin
    enable_d  = enable_q;
    trigger_d = trigger_q;
    if (en_wr_s) begin
      enable_d = wr_vec_s;
    end else begin
      enable_d = enable_q;
    end
    if (trig_wr_s) begin
      trigger_d = wr_vec_s;
    end else begin
      trigger_d = trigger_q;
    end
  end

  // Read data mux; reads see pre-write state, unmapped reads return zero.
  always_comb begin
    rdata_d = rdata_q;
    if (bus.rd) begin
      if (hit_s) begin
        case (off_s)
          OFF_PENDING:   rdata_d = XL'(pending_q);
          OFF_ENABLE:    rdata_d = XL'(enable_q);
          OFF_TRIGGER:   rdata_d = XL'(trigger_q);
          OFF_INSERVICE: rdata_d = XL'(inservice_q);
          OFF_CLAIM:     rdata_d = XL'(claim_id_s);
          default:       rdata_d = {XL{1'b0}};
        endcase
      end else begin
        rdata_d = {XL{1'b0}};
      end
    end else begin
      rdata_d = rdata_q;
    end
  end

  // State register; reset clears everything, exti drops asynchronously.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pending_q   <= {(N_SRC+1){1'b0}};
      enable_q    <= {(N_SRC+1){1'b0}};
      trigger_q   <= {(N_SRC+1){1'b0}};
      inservice_q <= {(N_SRC+1){1'b0}};
      latch_q     <= {(N_SRC+1){1'b0}};
      prev_q      <= {(N_SRC+1){1'b0}};
      exti_q      <= 1'b0;
      rdata_q     <= {XL{1'b0}};
    end else begin
      pending_q   <= pending_d;
      enable_q    <= enable_d;
      trigger_q   <= trigger_d;
      inservice_q <= inservice_d;
      latch_q     <= latch_d;
      prev_q      <= prev_d;
      exti_q      <= exti_d;
      rdata_q     <= rdata_d;
    end
  end

  assign bus.rdata = rdata_q;
  assign exti      = exti_q;

endmodule
